// File: rtl/csr_tohost_unit.sv
// rtl/csr_tohost_unit.sv - tohost/cycle/instret CSR unit with test completion tracking
// Optional watchdog timeout enabled by defining TOHOST_WATCHDOG_EN.
module csr_tohost_unit #(
  parameter int WATCHDOG_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic        csr_stall,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  input  logic        instret_inc,
  output logic [31:0] csr_rdata,
  output logic        csr_rdata_valid,
  output logic [31:0] tohost,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] fail_id,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count,
  output logic        illegal_csr,
  output logic        timeout
);

  localparam logic [11:0] ADDR_TOHOST  = 12'h51E;
  localparam logic [11:0] ADDR_CYCLE   = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET = 12'hC02;
  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  typedef enum logic {RUN, DONE} state_t;
  state_t state, state_nxt;

  logic        accept, hit_tohost, hit_ro, illegal;
  logic        tohost_wr, done_wr, wd_expire;
  logic [31:0] old_val, new_val;

  always_comb begin
    accept     = csr_valid && !csr_stall && (csr_op != 2'b00);
    hit_tohost = (csr_addr == ADDR_TOHOST);
    hit_ro     = (csr_addr == ADDR_CYCLE) || (csr_addr == ADDR_INSTRET);
    // Read-only counters tolerate RS/RC with a zero operand as a pure read.
    illegal    = !(hit_tohost || hit_ro) ||
                 (hit_ro && ((csr_op == OP_RW) || (csr_wdata != 32'h0)));
    old_val = 32'h0;
    if (hit_tohost)
      old_val = tohost;
    else if (csr_addr == ADDR_CYCLE)
      old_val = cycle_count;
    else if (csr_addr == ADDR_INSTRET)
      old_val = instret_count;
    new_val = tohost;
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_RS:   new_val = tohost | csr_wdata;
      OP_RC:   new_val = tohost & ~csr_wdata;
      default: new_val = tohost;
    endcase
    tohost_wr = accept && hit_tohost && (state == RUN);
    done_wr   = tohost_wr && new_val[0];
  end

`ifdef TOHOST_WATCHDOG_EN
  logic [31:0] wd_count;

  // A completing write in the expiry cycle takes precedence over the timeout.
  assign wd_expire = (state == RUN) && (wd_count == 32'(WATCHDOG_CYCLES - 1)) && !done_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_count <= 32'h0;
      timeout  <= 1'b0;
    end else begin
      if (state == RUN)
        wd_count <= wd_count + 32'd1;
      if (wd_expire)
        timeout <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (done_wr || wd_expire) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign test_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata       <= 32'h0;
      csr_rdata_valid <= 1'b0;
      illegal_csr     <= 1'b0;
      tohost          <= 32'h0;
      fail_id         <= 31'h0;
      test_pass       <= 1'b0;
      cycle_count     <= 32'h0;
      instret_count   <= 32'h0;
    end else begin
      csr_rdata_valid <= accept;
      illegal_csr     <= accept && illegal;
      if (accept)
        csr_rdata <= old_val;
      if (tohost_wr)
        tohost <= new_val;
      if (done_wr) begin
        fail_id   <= new_val[31:1];
        test_pass <= (new_val[31:1] == 31'h0);
      end else if (wd_expire) begin
        fail_id   <= '1;
        test_pass <= 1'b0;
      end
      // Counters still advance on the edge that enters DONE, then freeze.
      if (state == RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (instret_inc)
          instret_count <= instret_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_tohost_unit.sv
// tb/tb_csr_tohost_unit.sv - scoreboard bench for csr_tohost_unit
module tb_csr_tohost_unit;

  localparam logic [11:0] A_TOHOST  = 12'h51E;
  localparam logic [11:0] A_CYCLE   = 12'hC00;
  localparam logic [11:0] A_INSTRET = 12'hC02;
  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_valid = 1'b0;
  logic        csr_stall = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [1:0]  csr_op = 2'b00;
  logic [31:0] csr_wdata = 32'h0;
  logic        instret_inc = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_rdata_valid;
  logic [31:0] tohost;
  logic        test_done;
  logic        test_pass;
  logic [30:0] fail_id;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
  logic        illegal_csr;
  logic        timeout;

  csr_tohost_unit dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_stall(csr_stall),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata), .instret_inc(instret_inc),
    .csr_rdata(csr_rdata), .csr_rdata_valid(csr_rdata_valid), .tohost(tohost),
    .test_done(test_done), .test_pass(test_pass), .fail_id(fail_id),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .illegal_csr(illegal_csr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] run_edges = 32'h0;
  logic [31:0] ins_edges = 32'h0;
  logic [31:0] cyc_base = 32'h0;
  logic [31:0] ins_base = 32'h0;
  logic [31:0] m_tohost = 32'h0;
  logic        m_done = 1'b0;
  logic        m_pass = 1'b0;
  logic [30:0] m_fail = 31'h0;

  // Reference counters: advance on every running edge, freeze once the model completes.
  always @(posedge clk) begin
    if (rst) begin
      run_edges <= 32'h0;
      ins_edges <= 32'h0;
    end else if (!m_done) begin
      run_edges <= run_edges + 32'd1;
      if (instret_inc)
        ins_edges <= ins_edges + 32'd1;
    end
  end

  function automatic logic [31:0] exp_cyc();
    return cyc_base + run_edges;
  endfunction

  function automatic logic [31:0] exp_ins();
    return ins_base + ins_edges;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    csr_valid = 1'b1; csr_stall = 1'b0; csr_addr = A_TOHOST; csr_op = OP_RW;
    csr_wdata = 32'h1; instret_inc = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0; instret_inc = 1'b0;
    m_tohost = 32'h0; m_done = 1'b0; m_pass = 1'b0; m_fail = 31'h0;
    cyc_base = 32'h0; ins_base = 32'h0;
    sb.delete();
  endtask

  task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic stall, input logic inc);
    logic [31:0] old, nv;
    logic        ro, pend;
    exp_t        e;
    pend = 1'b0;
    @(negedge clk);
    csr_valid = 1'b1; csr_stall = stall; csr_addr = a; csr_op = op; csr_wdata = wd;
    instret_inc = inc;
    if (!stall && op != 2'b00) begin
      ro  = (a == A_CYCLE) || (a == A_INSTRET);
      old = (a == A_TOHOST) ? m_tohost : (a == A_CYCLE) ? exp_cyc() :
            (a == A_INSTRET) ? exp_ins() : 32'h0;
      e.rdata = old;
      e.ill   = !((a == A_TOHOST) || ro) || (ro && (op == OP_RW || wd != 32'h0));
      sb.push_back(e);
      if (a == A_TOHOST && !m_done) begin
        nv = (op == OP_RW) ? wd : (op == OP_RS) ? (old | wd) : (old & ~wd);
        m_tohost = nv;
        if (nv[0]) begin
          pend   = 1'b1;
          m_fail = nv[31:1];
          m_pass = (nv[31:1] == 31'h0);
        end
      end
    end
    @(posedge clk);
    #1;
    if (pend) m_done = 1'b1;
    csr_valid = 1'b0; csr_stall = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0; instret_inc = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL reset_tohost got=%h want=0", tohost); end
    checks++; if (test_done !== 1'b0) begin failures++; $display("FAIL reset_test_done got=%b want=0", test_done); end
    checks++; if (test_pass !== 1'b0) begin failures++; $display("FAIL reset_test_pass got=%b want=0", test_pass); end
    checks++; if (fail_id !== 31'h0) begin failures++; $display("FAIL reset_fail_id got=%h want=0", fail_id); end
    checks++; if (cycle_count !== 32'h0) begin failures++; $display("FAIL reset_cycle got=%h want=0", cycle_count); end
    checks++; if (instret_count !== 32'h0) begin failures++; $display("FAIL reset_instret got=%h want=0", instret_count); end
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", csr_rdata); end
    checks++; if (csr_rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_rdata_valid got=%b want=0", csr_rdata_valid); end
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b want=0", illegal_csr); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL reset_cycle_run got=%h want=3", cycle_count); end
  endtask

  task automatic test_pass_done();
    exp_t e;
    do_reset();
    issue(A_TOHOST, OP_RW, 32'h1, 1'b0, 1'b0);
    checks++;
    if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL pass_rvalid got=%b want=1", csr_rdata_valid); end
    else begin
      e = sb.pop_front();
      checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL pass_rdata got=%h want=%h", csr_rdata, e.rdata); end
    end
    checks++; if (test_done !== 1'b1) begin failures++; $display("FAIL pass_done got=%b want=1", test_done); end
    checks++; if (test_pass !== m_pass || m_pass !== 1'b1) begin failures++; $display("FAIL pass_pass got=%b want=1", test_pass); end
    checks++; if (fail_id !== m_fail) begin failures++; $display("FAIL pass_fail_id got=%h want=%h", fail_id, m_fail); end
    checks++; if (cycle_count !== exp_cyc()) begin failures++; $display("FAIL pass_cycle got=%h want=%h", cycle_count, exp_cyc()); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (cycle_count !== exp_cyc()) begin failures++; $display("FAIL pass_cycle_frozen got=%h want=%h", cycle_count, exp_cyc()); end
  endtask

  task automatic test_fail_done();
    exp_t e;
    do_reset();
    issue(A_TOHOST, OP_RW, 32'h7, 1'b0, 1'b0);
    if (sb.size() != 0) e = sb.pop_front();
    checks++; if (test_done !== 1'b1) begin failures++; $display("FAIL fail_done got=%b want=1", test_done); end
    checks++; if (test_pass !== 1'b0) begin failures++; $display("FAIL fail_pass got=%b want=0", test_pass); end
    checks++; if (fail_id !== 31'd3) begin failures++; $display("FAIL fail_id got=%h want=3", fail_id); end
    issue(A_TOHOST, OP_RW, 32'h1, 1'b0, 1'b0);
    checks++;
    if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL fail_rvalid got=%b want=1", csr_rdata_valid); end
    else begin
      e = sb.pop_front();
      checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL fail_rdata got=%h want=%h", csr_rdata, e.rdata); end
    end
    checks++; if (tohost !== 32'h7) begin failures++; $display("FAIL fail_tohost_sticky got=%h want=7", tohost); end
    do_reset();
    #1;
    checks++; if (test_done !== 1'b0) begin failures++; $display("FAIL fail_reset_run got=%b want=0", test_done); end
  endtask

  task automatic test_set_clear();
    exp_t e;
    do_reset();
    issue(A_TOHOST, OP_RS, 32'h4, 1'b0, 1'b0);
    checks++;
    if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL rs_rvalid got=%b want=1", csr_rdata_valid); end
    else begin
      e = sb.pop_front();
      checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL rs_rdata got=%h want=%h", csr_rdata, e.rdata); end
    end
    checks++; if (tohost !== 32'h4) begin failures++; $display("FAIL rs_tohost got=%h want=4", tohost); end
    issue(A_TOHOST, OP_RC, 32'h4, 1'b1, 1'b0);
    checks++; if (csr_rdata_valid !== 1'b0 || sb.size() != 0) begin failures++; $display("FAIL stall_rvalid got=%b want=0", csr_rdata_valid); end
    checks++; if (tohost !== 32'h4) begin failures++; $display("FAIL stall_tohost got=%h want=4", tohost); end
    issue(A_TOHOST, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++; if (csr_rdata_valid !== 1'b0 || tohost !== 32'h4) begin failures++; $display("FAIL noop got=%b/%h want=0/4", csr_rdata_valid, tohost); end
    issue(A_TOHOST, OP_RC, 32'h4, 1'b0, 1'b0);
    checks++;
    if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL rc_rvalid got=%b want=1", csr_rdata_valid); end
    else begin
      e = sb.pop_front();
      checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL rc_rdata got=%h want=%h", csr_rdata, e.rdata); end
    end
    checks++; if (tohost !== 32'h0 || test_done !== 1'b0) begin failures++; $display("FAIL rc_tohost got=%h/%b want=0/0", tohost, test_done); end
  endtask

  task automatic test_illegal();
    logic [11:0] ta[6] = '{A_TOHOST, A_CYCLE, A_INSTRET, A_CYCLE, A_CYCLE, 12'h123};
    logic [1:0]  to[6] = '{OP_RW, OP_RW, OP_RS, OP_RC, OP_RS, OP_RS};
    logic [31:0] tw[6] = '{32'h6, 32'h5, 32'h0, 32'h1, 32'h0, 32'h0};
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], to[i], tw[i], 1'b0, 1'b1);
      checks++;
      if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL ill_rvalid[%0d] got=%b want=1", i, csr_rdata_valid); end
      else begin
        e = sb.pop_front();
        checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL ill_rdata[%0d] got=%h want=%h", i, csr_rdata, e.rdata); end
        checks++; if (illegal_csr !== e.ill) begin failures++; $display("FAIL ill_flag[%0d] got=%b want=%b", i, illegal_csr, e.ill); end
      end
      checks++; if (cycle_count !== exp_cyc()) begin failures++; $display("FAIL ill_cycle[%0d] got=%h want=%h", i, cycle_count, exp_cyc()); end
      checks++; if (tohost !== m_tohost) begin failures++; $display("FAIL ill_tohost[%0d] got=%h want=%h", i, tohost, m_tohost); end
    end
    @(posedge clk);
    #1;
    checks++; if (illegal_csr !== 1'b0) begin failures++; $display("FAIL ill_pulse got=%b want=0", illegal_csr); end
  endtask

  task automatic test_counters();
    exp_t e;
    do_reset();
    @(negedge clk);
    instret_inc = 1'b1;
    repeat (10) @(negedge clk);
    instret_inc = 1'b0;
    issue(A_INSTRET, OP_RS, 32'h0, 1'b0, 1'b0);
    checks++; if (csr_rdata !== 32'd10) begin failures++; $display("FAIL instret_read got=%h want=10", csr_rdata); end
    if (sb.size() != 0) e = sb.pop_front();
    issue(A_CYCLE, OP_RC, 32'h0, 1'b0, 1'b1);
    checks++;
    if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL cyc_rvalid got=%b want=1", csr_rdata_valid); end
    else begin
      e = sb.pop_front();
      checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL cyc_read got=%h want=%h", csr_rdata, e.rdata); end
    end
    checks++; if (instret_count !== 32'd11) begin failures++; $display("FAIL instret_simul got=%h want=11", instret_count); end
    @(negedge clk);
    force dut.cycle_count = 32'hFFFF_FFFE;
    force dut.instret_count = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count;
    release dut.instret_count;
    cyc_base = 32'hFFFF_FFFE - run_edges;
    ins_base = 32'hFFFF_FFFF - ins_edges;
    instret_inc = 1'b1;
    @(negedge clk);
    checks++; if (instret_count !== 32'h0) begin failures++; $display("FAIL instret_wrap got=%h want=0", instret_count); end
    @(negedge clk);
    instret_inc = 1'b0;
    checks++; if (cycle_count !== 32'h0) begin failures++; $display("FAIL cycle_wrap got=%h want=0", cycle_count); end
    checks++; if (instret_count !== exp_ins()) begin failures++; $display("FAIL instret_model got=%h want=%h", instret_count, exp_ins()); end
    issue(A_TOHOST, OP_RW, 32'h1, 1'b0, 1'b1);
    if (sb.size() != 0) e = sb.pop_front();
    checks++; if (instret_count !== 32'd2) begin failures++; $display("FAIL instret_done_edge got=%h want=2", instret_count); end
    @(negedge clk);
    instret_inc = 1'b1;
    repeat (3) @(negedge clk);
    instret_inc = 1'b0;
    checks++; if (instret_count !== 32'd2 || cycle_count !== exp_cyc()) begin failures++; $display("FAIL counters_frozen got=%h/%h want=2/%h", instret_count, cycle_count, exp_cyc()); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] wd;
    exp_t        e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      op = 2'(1 + $urandom_range(0, 2));
      wd = $urandom() & 32'hFFFF_FFFE;
      if (i % 3 == 2) issue(A_CYCLE, OP_RS, 32'h0, 1'b0, 1'b0);
      else            issue(A_TOHOST, op, wd, 1'b0, 1'b0);
      checks++;
      if (csr_rdata_valid !== 1'b1 || sb.size() == 0) begin failures++; $display("FAIL b2b_rvalid[%0d] got=%b want=1", i, csr_rdata_valid); end
      else begin
        e = sb.pop_front();
        checks++; if (csr_rdata !== e.rdata) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h want=%h", i, csr_rdata, e.rdata); end
      end
      checks++; if (tohost !== m_tohost) begin failures++; $display("FAIL b2b_tohost[%0d] got=%h want=%h", i, tohost, m_tohost); end
    end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
`ifdef TOHOST_WATCHDOG_EN
    n = 0;
    while (test_done !== 1'b1 && n < 2100) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_done = 1'b1;
    checks++; if (test_done !== 1'b1) begin failures++; $display("FAIL wd_done got=%b want=1 after %0d", test_done, n); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wd_timeout got=%b want=1", timeout); end
    checks++; if (fail_id !== 31'h7FFF_FFFF) begin failures++; $display("FAIL wd_fail_id got=%h want=7fffffff", fail_id); end
    checks++; if (test_pass !== 1'b0) begin failures++; $display("FAIL wd_pass got=%b want=0", test_pass); end
    checks++; if (cycle_count !== 32'd2000) begin failures++; $display("FAIL wd_cycle got=%0d want=2000", cycle_count); end
`else
    n = 50;
    repeat (n) @(posedge clk);
    #1;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL nowd_timeout got=%b want=0", timeout); end
    checks++; if (test_done !== 1'b0) begin failures++; $display("FAIL nowd_done got=%b want=0", test_done); end
`endif
  endtask

  initial begin
    test_reset();
    test_pass_done();
    test_fail_done();
    test_set_clear();
    test_illegal();
    test_counters();
    test_back_to_back();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_tohost_unit.md
CSR_TOHOST_UNIT -- requirements
Module: csr_tohost_unit

Interface
REQ-001 SHALL have parameter WATCHDOG_CYCLES, default 2000: cycles in RUN before timeout asserts (used only with Configuration macro).
REQ-002 SHALL have clk  input  1  clock; all state changes on posedge clk.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have csr_valid  input  1  CSR instruction present this cycle.
REQ-005 SHALL have csr_stall  input  1  pipeline stall; suppresses accept of csr_valid.
REQ-006 SHALL have csr_addr  input  12  CSR address.
REQ-007 SHALL have csr_op  input  2  01 RW, 10 RS (set bits), 11 RC (clear bits), 00 no-op.
REQ-008 SHALL have csr_wdata  input  32  write operand (rs1 or zero-extended uimm).
REQ-009 SHALL have instret_inc  input  1  one instruction retired this cycle.
REQ-010 SHALL have csr_rdata  output  32  registered read data (old CSR value).
REQ-011 SHALL have csr_rdata_valid  output  1  one-cycle pulse qualifying csr_rdata.
REQ-012 SHALL have tohost  output  32  current tohost register (0x51E).
REQ-013 SHALL have test_done, test_pass  output  1 each  completion flags.
REQ-014 SHALL have fail_id  output  31  tohost[31:1] latched at completion.
REQ-015 SHALL have cycle_count, instret_count  output  32 each  free-running counters.
REQ-016 SHALL have illegal_csr  output  1  one-cycle pulse on illegal access; timeout output 1 (Configuration).

Function
REQ-017 Accept = csr_valid && !csr_stall && csr_op!=00; nothing changes when not accepted.
REQ-018 Address map SHALL be: 0x51E tohost (RW), 0xC00 cycle (RO), 0xC02 instret (RO).
REQ-019 On accept, csr_rdata SHALL present the pre-write value one cycle later with csr_rdata_valid=1; unmapped address -> rdata 0.
REQ-020 New tohost value: RW wdata; RS old|wdata; RC old&~wdata; written on the accept edge.
REQ-021 Illegal (pulse next cycle, no state change) SHALL be: unmapped address, or RO address with op RW, or RO address with RS/RC and wdata!=0.
REQ-022 State machine SHALL have states RUN, DONE: RUN->DONE when accepted tohost write yields new[0]=1; DONE is sticky until reset.
REQ-023 In DONE, tohost writes SHALL be ignored (reads still return data); test_done=1.
REQ-024 On entering DONE: fail_id<=new[31:1], test_pass<=(new[31:1]==0), both registered with test_done in the same cycle.
REQ-025 tohost write with new[0]=0 in RUN SHALL update tohost and remain RUN.
REQ-026 cycle_count SHALL increment every cycle in RUN, freeze in DONE, wrap 0xFFFFFFFF->0.
REQ-027 instret_count SHALL increment on instret_inc in RUN, freeze in DONE, wrap likewise.
REQ-028 Read of cycle/instret SHALL return the value before that cycle's increment; simultaneous read and increment both occur.
REQ-029 instret_inc in the same cycle as the DONE-causing write SHALL still count.

Reset
REQ-030 On rst: state RUN, tohost 0, test_done 0, test_pass 0, fail_id 0, counters 0, csr_rdata 0, csr_rdata_valid 0, illegal_csr 0, timeout 0.
REQ-031 rst SHALL override any accepted access in the same cycle; reset in DONE returns to RUN.

Configuration
REQ-032 Macro TOHOST_WATCHDOG_EN defined: a watchdog counter SHALL count RUN cycles; on reaching WATCHDOG_CYCLES, timeout=1 sticky, state->DONE, test_pass=0, fail_id=all ones.
REQ-033 Without TOHOST_WATCHDOG_EN: no watchdog logic, timeout tied 0, WATCHDOG_CYCLES unused.
REQ-034 Watchdog expiry and DONE-causing write in the same cycle: the write SHALL win (timeout stays 0).

Verification
REQ-035 Reset 30 cycles, RW 0x51E wdata 0x1 -> next cycle test_done=1, test_pass=1, fail_id=0, cycle_count frozen.
REQ-036 RW 0x51E wdata 0x7 -> test_done=1, test_pass=0, fail_id=3; later RW wdata 0x1 -> tohost stays 0x7.
REQ-037 RS 0x51E wdata 0x4 then RC wdata 0x4 with csr_stall=1 on the RC -> tohost=0x4, rdata of RS = 0, RC not applied.
REQ-038 RW 0xC00 wdata 5 -> illegal_csr pulse, cycle_count unaffected; RS 0xC02 wdata 0 -> legal read of instret; read 0x123 -> rdata 0, illegal pulse.
REQ-039 instret_inc held 10 cycles, then read 0xC02 -> rdata 10; force counters near 0xFFFFFFFF -> wrap to 0.
REQ-040 With TOHOST_WATCHDOG_EN, WATCHDOG_CYCLES=2000, no writes -> timeout=1 at cycle 2000, test_done=1, fail_id=0x7FFFFFFF.
